// File: rtl/lpc_dump_pkg.sv
// Shared types and constants for the LPC dump framer.
package lpc_dump_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        WAIT  = 3'd2,
        LATCH = 3'd3,
        HDR   = 3'd4,
        DATA  = 3'd5
    } state_t;

    // Header byte values: plain sync marker, or sync marker flagging lost entries.
    localparam logic [7:0] HDR_SYNC = 8'hA5;
    localparam logic [7:0] HDR_OVF  = 8'hA6;

endpackage

// File: rtl/lpc_dump_framer_if.sv
// Byte stream between the dump framer and the UART transmitter.
interface lpc_dump_framer_if;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/lpc_dump_framer.sv
// Pops ringbuffer entries and sends each one as a header byte plus the
// entry's bytes, most significant first, over a valid/ready byte stream.
module lpc_dump_framer
    import lpc_dump_pkg::*;
#(
    parameter int DW = 48
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rb_empty,
    input  logic                  rb_overflow,
    input  logic [DW-1:0]         rb_data,
    output logic                  rb_read,
    output logic                  busy,
    lpc_dump_framer_if.master     tx
);

    localparam int NBYTES = DW / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   sr;
    logic [IDX_W-1:0] idx;
    logic            ovf_seen;
    logic            hdr_ovf;
    logic            hs;

    // tx_valid is a pure state decode, so the handshake depends on state and tx_ready only.
    assign hs = ((state == HDR) || (state == DATA)) && tx.tx_ready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; rb_empty only matters in IDLE, so a frame always completes before the next pop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rb_empty) state_next = POP;
            POP:     state_next = WAIT;
            WAIT:    state_next = LATCH;
            LATCH:   state_next = HDR;
            HDR:     if (hs) state_next = DATA;
            DATA:    if (hs && (idx == LAST_IDX)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered frame contents only.
    always_comb begin
        rb_read     = (state == POP);
        busy        = (state != IDLE);
        tx.tx_valid = (state == HDR) || (state == DATA);
        tx.tx_data  = 8'h00;
        if (state == HDR) begin
            tx.tx_data = hdr_ovf ? HDR_OVF : HDR_SYNC;
        end else if (state == DATA) begin
            tx.tx_data = sr[DW-1 -: 8];
        end
    end

    // Shift register and byte index: load the popped entry, then shift out one byte per handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr  <= '0;
            idx <= '0;
        end else if (state == LATCH) begin
            sr  <= rb_data;
            idx <= '0;
        end else if ((state == DATA) && hs) begin
            sr  <= sr << 8;
            idx <= idx + IDX_W'(1);
        end
    end

    // Sticky overflow flag, handed to the header at LATCH; an overflow in that same cycle survives the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_seen <= 1'b0;
            hdr_ovf  <= 1'b0;
        end else begin
            ovf_seen <= rb_overflow | (ovf_seen & (state != LATCH));
            if (state == LATCH) begin
                hdr_ovf <= ovf_seen;
            end
        end
    end

endmodule

// File: tb/tb_lpc_dump_framer.sv
// Self-checking bench for lpc_dump_framer with a ringbuffer model and a byte-stream scoreboard.
module tb_lpc_dump_framer;
    import lpc_dump_pkg::*;

    localparam int DW = 48;
    localparam int NB = DW / 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rb_empty = 1'b1;
    logic          rb_overflow = 1'b0;
    logic [DW-1:0] rb_data = '0;
    logic          rb_read;
    logic          busy;

    lpc_dump_framer_if tx_if ();

    lpc_dump_framer #(.DW(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .rb_empty    (rb_empty),
        .rb_overflow (rb_overflow),
        .rb_data     (rb_data),
        .rb_read     (rb_read),
        .busy        (busy),
        .tx          (tx_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int rd_count = 0;

    logic [7:0]    got[$];
    int            got_cyc[$];
    logic [7:0]    exp[$];
    logic [DW-1:0] rbq[$];
    bit            prev_stall = 0;
    logic [7:0]    prev_data = 8'h00;

    // One clock cycle: observe mid-cycle, model the ringbuffer, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clock);
        if (reset) begin
            if (prev_stall) begin
                n_checks++;
                if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold_under_stall: valid=%b data=%h, required valid=1 data=%h",
                             tx_if.tx_valid, tx_if.tx_data, prev_data);
                end
            end
            if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
                got.push_back(tx_if.tx_data);
                got_cyc.push_back(cycle);
            end
            prev_stall = (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready === 1'b0);
            prev_data  = tx_if.tx_data;
        end else begin
            prev_stall = 0;
        end
        if (rb_read === 1'b1) begin
            rd_count++;
            if (rbq.size() > 0) rb_data = rbq.pop_front();
        end
        rb_empty = (rbq.size() == 0);
        @(posedge clock);
        cycle++;
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        rbq.push_back(d);
        rb_empty = 1'b0;
    endtask

    // Reference frame: header chosen by overflow history, then entry bytes MSB first.
    task automatic add_frame(input logic [DW-1:0] d, input bit ovf);
        exp.push_back(ovf ? 8'hA6 : 8'hA5);
        for (int k = 0; k < NB; k++) begin
            exp.push_back(8'((d >> (8 * (NB - 1 - k))) & {{(DW-8){1'b0}}, 8'hFF}));
        end
    endtask

    task automatic drain(input int n, input bit rnd, output bit ok);
        int budget;
        budget = 3000;
        ok = 0;
        while (budget > 0) begin
            tx_if.tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            if (got.size() >= n && busy === 1'b0 && rbq.size() == 0) begin
                ok = 1;
                break;
            end
            budget--;
        end
        tx_if.tx_ready = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_entry();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tx_if.tx_ready = 1'b1;
        #2;
        n_checks++; if (rb_read !== 1'b0) begin n_fail++; $display("FAIL reset_rb_read: got %b want 0", rb_read); end
        n_checks++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_if.tx_valid); end
        n_checks++; if (tx_if.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_if.tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_empty_idle();
        int bad_rd, bad_vld;
        bad_rd = 0;
        bad_vld = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++; if (rb_read !== 1'b0) begin n_fail++; bad_rd++; if (bad_rd < 4) $display("FAIL empty_rb_read: got %b want 0", rb_read); end
            n_checks++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; bad_vld++; if (bad_vld < 4) $display("FAIL empty_tx_valid: got %b want 0", tx_if.tx_valid); end
        end
    endtask

    task automatic test_single();
        bit ok;
        int r0;
        got.delete(); got_cyc.delete(); exp.delete();
        r0 = rd_count;
        push(48'h0123_4567_89AB);
        add_frame(48'h0123_4567_89AB, 1'b0);
        drain(exp.size(), 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d bytes want %0d", got.size(), exp.size()); end
        n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        n_checks++; if (rd_count - r0 != 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", rd_count - r0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int budget;
        logic [DW-1:0] d;
        got.delete(); got_cyc.delete(); exp.delete();
        d = 48'h0123_4567_89AB;
        push(d);
        add_frame(d, 1'b0);
        tx_if.tx_ready = 1'b1;
        budget = 50;
        while (got.size() < 2 && budget > 0) begin tick(); budget--; end
        n_checks++; if (budget == 0) begin n_fail++; $display("FAIL bp_reach_third: got %0d bytes want 2", got.size()); end
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (tx_if.tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want 1", i, tx_if.tx_valid); end
            n_checks++; if (tx_if.tx_data !== 8'h23) begin n_fail++; $display("FAIL bp_data_c%0d: got %h want 23", i, tx_if.tx_data); end
            tick();
        end
        drain(exp.size(), 1'b0, ok);
        n_checks++; if (!ok || got.size() != exp.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [DW-1:0] d;
        got.delete(); got_cyc.delete(); exp.delete();
        for (int i = 0; i < 6; i++) begin
            d = rand_entry();
            push(d);
            add_frame(d, 1'b0);
        end
        drain(exp.size(), 1'b1, ok);
        n_checks++; if (!ok || got.size() != exp.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] d;
        got.delete(); got_cyc.delete(); exp.delete();
        for (int i = 0; i < 3; i++) begin
            d = rand_entry();
            push(d);
            add_frame(d, 1'b0);
        end
        drain(exp.size(), 1'b0, ok);
        n_checks++; if (!ok || got.size() != 3 * (NB + 1)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got.size(), 3 * (NB + 1)); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        if (got_cyc.size() >= 3 * (NB + 1)) begin
            for (int f = 1; f < 3; f++) begin
                n_checks++;
                if (got_cyc[f * (NB + 1)] - got_cyc[(f - 1) * (NB + 1)] != 4 + 1 + NB) begin
                    n_fail++;
                    $display("FAIL b2b_period%0d: got %0d cycles want %0d", f,
                             got_cyc[f * (NB + 1)] - got_cyc[(f - 1) * (NB + 1)], 4 + 1 + NB);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int budget;
        logic [DW-1:0] d;
        // Overflow while idle: only the next frame is marked.
        got.delete(); got_cyc.delete(); exp.delete();
        rb_overflow = 1'b1;
        tick(); tick(); tick();
        rb_overflow = 1'b0;
        d = rand_entry(); push(d); add_frame(d, 1'b1);
        d = rand_entry(); push(d); add_frame(d, 1'b0);
        drain(exp.size(), 1'b0, ok);
        n_checks++; if (!ok || got.size() != exp.size()) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        // Overflow in the LATCH cycle (two cycles after the pop strobe): marks the following frame.
        got.delete(); got_cyc.delete(); exp.delete();
        d = rand_entry(); push(d); add_frame(d, 1'b0);
        budget = 20;
        while (rb_read !== 1'b1 && budget > 0) begin tick(); budget--; end
        n_checks++; if (budget == 0) begin n_fail++; $display("FAIL ovf_pop_seen: got rb_read=%b want 1", rb_read); end
        tick();
        tick();
        rb_overflow = 1'b1;
        tick();
        rb_overflow = 1'b0;
        d = rand_entry(); push(d); add_frame(d, 1'b1);
        d = rand_entry(); push(d); add_frame(d, 1'b0);
        drain(exp.size(), 1'b0, ok);
        n_checks++; if (!ok || got.size() != exp.size()) begin n_fail++; $display("FAIL ovf_latch_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_latch_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int budget;
        logic [DW-1:0] d;
        got.delete(); got_cyc.delete(); exp.delete();
        push(rand_entry());
        tx_if.tx_ready = 1'b1;
        budget = 50;
        while (got.size() < 3 && budget > 0) begin tick(); budget--; end
        n_checks++; if (budget == 0) begin n_fail++; $display("FAIL mid_reach_idx2: got %0d bytes want 3", got.size()); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (rb_read !== 1'b0) begin n_fail++; $display("FAIL mid_rb_read: got %b want 0", rb_read); end
        n_checks++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tx_valid: got %b want 0", tx_if.tx_valid); end
        n_checks++; if (tx_if.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h want 00", tx_if.tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        tick();
        tick();
        reset = 1'b1;
        got.delete(); got_cyc.delete(); exp.delete();
        d = rand_entry(); push(d); add_frame(d, 1'b0);
        drain(exp.size(), 1'b0, ok);
        n_checks++; if (got.size() == 0 || got[0] !== 8'hA5) begin n_fail++; $display("FAIL mid_first_is_header: got %h want a5", (got.size() > 0) ? got[0] : 8'hxx); end
        n_checks++; if (!ok || got.size() != exp.size()) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL mid_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    initial begin
        tx_if.tx_ready = 1'b0;
        test_reset();
        test_empty_idle();
        test_single();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lpc_dump_framer.md
# lpc_dump_framer

Drain stage between the LPC capture `ringbuffer` and the UART transmitter. When the ringbuffer is non-empty, it pops one DW-bit entry and emits it as a byte frame over a valid/ready byte stream. The frame is one header byte followed by DW/8 data bytes, most significant byte first. The header also reports, out of band, whether the ringbuffer overflowed since the previous frame.

## Interface
- DW, 48, ringbuffer entry width; must be a multiple of 8.
- NBYTES, DW/8, data bytes per frame; derived, not overridable.
- clock  in  1  system clock; this block uses the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- rb_empty  in  1  ringbuffer empty flag.
- rb_overflow  in  1  ringbuffer overflow flag (level).
- rb_data  in  DW  ringbuffer read data.
- rb_read  out  1  one-cycle pop strobe; drives the ringbuffer's read_clock_enable.
- tx_valid  out  1  byte on tx_data is offered.
- tx_ready  in  1  UART accepts the byte.
- tx_data  out  8  byte to transmit.
- busy  out  1  high whenever state != IDLE.

## Operation
- **States:**
  - IDLE -> POP when rb_empty=0.
  - POP -> WAIT unconditionally.
  - WAIT -> LATCH unconditionally.
  - LATCH -> HDR unconditionally.
  - HDR -> DATA on handshake.
  - DATA -> DATA on handshake while idx < NBYTES-1.
  - DATA -> IDLE on handshake at idx = NBYTES-1.
- **Handshake:** a byte transfers on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_valid is high only in HDR and DATA.
  - While tx_valid=1 and tx_ready=0, tx_data and the state hold unchanged.
  - tx_valid never drops before the transfer.
- **POP:** rb_read=1 for exactly this one cycle; it is 0 in every other state. The ringbuffer updates on the falling edge inside POP.
- **WAIT:** absorbs the ringbuffer/buffer read latency.
- **LATCH:** shift register `sr <= rb_data`.
- **Header byte:** 0xA5 when the captured overflow bit is 0, 0xA6 when it is 1.
- **DATA:** tx_data = sr[DW-1:DW-8]. On each handshake, sr shifts left 8 bits and idx increments. idx is clog2(NBYTES) bits and is cleared in LATCH.
- **Overflow tracking:** sticky flag ovf_seen is set in any cycle with rb_overflow=1.
  - In LATCH, hdr_ovf <= ovf_seen and ovf_seen clears.
  - If rb_overflow=1 in the LATCH cycle itself, ovf_seen stays set (set wins over clear).
- **rb_empty:** sampled only in IDLE. A new pop never starts before the current frame's last byte is accepted.
- **Back-to-back operation:** if rb_empty=0 on the cycle of the final DATA handshake, the next cycle is IDLE, and POP follows on the cycle after that.

## Timing
- **Reset values:** rb_read=0, tx_valid=0, tx_data=0x00, busy=0, state=IDLE, sr=0, idx=0, ovf_seen=0, hdr_ovf=0.
- **Reset mid-frame:** the partial frame is abandoned with no resume. The popped entry is lost. The first byte after reset is always a header.
- **Latency:** rb_empty falling (sampled in IDLE at edge T) -> rb_read high in cycle T+1. First tx_valid (header) appears in cycle T+4.
- **Minimum frame period** with tx_ready tied high: 4 + 1 + NBYTES cycles, i.e. 11 cycles for DW=48.
- **Outputs:** registered or decoded from state/sr only. No combinational path from tx_ready to tx_valid/tx_data.

## Structure
- **Package lpc_dump_pkg:**
  - state enum (IDLE, POP, WAIT, LATCH, HDR, DATA).
  - HDR_SYNC = 8'hA5 and HDR_OVF = 8'hA6.
- **No sub-module.**
  - The shift register and index live inline.
  - The UART transmitter stays a separate sibling, connected through tx_valid/tx_ready/tx_data.

## Test plan
- **Single entry:** push 48'h0123_4567_89AB with tx_ready=1. Expect bytes A5,01,23,45,67,89,AB; exactly one rb_read pulse; busy low afterwards.
- **Backpressure:** tx_ready=0 for 5 cycles during the third byte. Expect tx_data=0x23 held stable with tx_valid=1, then the frame completes with no byte duplicated or skipped.
- **Overflow marker:** fill the ringbuffer until rb_overflow=1, then drain.
  - First frame header 0xA6; subsequent frames 0xA5.
  - rb_overflow=1 during LATCH: next frame header also 0xA6.
- **Back-to-back:** 3 entries queued, tx_ready=1. Expect 21 bytes in order and frame starts 11 cycles apart.
- **Reset mid-frame:** assert reset during DATA idx=2.
  - All outputs 0 immediately (asynchronous).
  - After release with one entry queued, the next byte out is a header.
- **Empty idle:** rb_empty=1 for 50 cycles. Expect rb_read=0 and tx_valid=0 throughout.
